// File: rtl/hazard_sched_ctrl.sv
// Hazard scheduler for the 5-stage core: Tuse/Tnew stall detection, forwarding selects, MDU busy sequencing.
// Optional performance counters (StallCnt, MdStallCnt) are built when HAZARD_PERF_EN is defined.
module hazard_sched_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic       MdUseD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [4:0] RegDstE,
    input  logic [4:0] RegDstM,
    input  logic [4:0] RegDstW,
    input  logic [1:0] TnewE,
    input  logic [1:0] TnewM,
    input  logic       MdStartE,
    input  logic       MdIsDivE,
    input  logic [4:0] RtM,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic [1:0] FwdRsD,
    output logic [1:0] FwdRtD,
    output logic [1:0] FwdRsE,
    output logic [1:0] FwdRtE,
    output logic       FwdRtM,
    output logic       MdBusy
`ifdef HAZARD_PERF_EN
   ,output logic [31:0] StallCnt,
    output logic [31:0] MdStallCnt
`endif
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_t  state_r;
    md_state_t  state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       gpr_stall_s;
    logic       md_stall_s;
    logic       stall_s;

    // Register 0 is hardwired zero, so it never matches a producer.
    function automatic logic match(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && (dst == src) && (src != 5'd0);
    endfunction

    // Nearest ready producer wins: M (1) ahead of W (2); otherwise the local value (0).
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic we_m, input logic [4:0] dst_m,
                                           input logic [1:0] tnew_m, input logic we_w, input logic [4:0] dst_w);
        logic [1:0] sel;
        if (match(we_m, dst_m, src) && (tnew_m == 2'd0)) begin
            sel = 2'd1;
        end else if (match(we_w, dst_w, src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Stall detection: data not ready in time, or MDU occupied/being started.
    always_comb begin
        gpr_stall_s = (match(RegWriteE, RegDstE, RsD) && (TuseRsD < TnewE)) ||
                      (match(RegWriteM, RegDstM, RsD) && (TuseRsD < TnewM)) ||
                      (match(RegWriteE, RegDstE, RtD) && (TuseRtD < TnewE)) ||
                      (match(RegWriteM, RegDstM, RtD) && (TuseRtD < TnewM));
        md_stall_s  = MdUseD && ((state_r != MD_IDLE) || MdStartE);
        stall_s     = gpr_stall_s || md_stall_s;
        StallF      = stall_s;
        StallD      = stall_s;
        FlushE      = stall_s;
        MdBusy      = (state_r != MD_IDLE);
    end

    // Forwarding selects for D, E and M consumers.
    always_comb begin
        FwdRsD = fwd_sel(RsD, RegWriteM, RegDstM, TnewM, RegWriteW, RegDstW);
        FwdRtD = fwd_sel(RtD, RegWriteM, RegDstM, TnewM, RegWriteW, RegDstW);
        FwdRsE = fwd_sel(RsE, RegWriteM, RegDstM, TnewM, RegWriteW, RegDstW);
        FwdRtE = fwd_sel(RtE, RegWriteM, RegDstM, TnewM, RegWriteW, RegDstW);
        FwdRtM = match(RegWriteW, RegDstW, RtM);
    end

    // MDU next-state: a start while busy is ignored and does not reload the counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (MdStartE && MdIsDivE) begin
                    state_nxt_s = MD_DIV;
                    cnt_nxt_s   = DIV_LOAD;
                end else if (MdStartE) begin
                    state_nxt_s = MD_MUL;
                    cnt_nxt_s   = MULT_LOAD;
                end else begin
                    state_nxt_s = MD_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            MD_MUL, MD_DIV: begin
                if (cnt_r != 4'd0) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = MD_IDLE;
                end
            end
            default: begin
                state_nxt_s = MD_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // MDU state and countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] md_stall_cnt_r;

    // Stall-cycle counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r    <= 32'd0;
            md_stall_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r    <= stall_cnt_r + {31'd0, stall_s};
            md_stall_cnt_r <= md_stall_cnt_r + {31'd0, md_stall_s};
        end
    end

    assign StallCnt   = stall_cnt_r;
    assign MdStallCnt = md_stall_cnt_r;
`endif

endmodule
